// File: rtl/auth_pkg.sv
// Shared definitions for the code-lock authenticator.
//   ST_UNSET/ST_ARMED/ST_LOCKOUT : state encodings
//   auth_state_e                 : typed FSM state built on those encodings
//   cnt_width()                  : bits needed to hold the values 0..max_val
package auth_pkg;

    localparam logic [1:0] ST_UNSET   = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    typedef enum logic [1:0] {
        StUnset   = ST_UNSET,
        StArmed   = ST_ARMED,
        StLockout = ST_LOCKOUT
    } auth_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/auth_compare.sv
// Combinational code comparator.
//   a, b  : codes to compare (WIDTH bits)
//   eq    : 1 when every bit of a matches b (XNOR reduce)
//   dist  : Hamming distance of a and b; present only when AUTH_HAMMING_EN is defined
module auth_compare #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIST_W = 4
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
`ifdef AUTH_HAMMING_EN
    output logic [DIST_W-1:0] dist,
`endif
    output logic              eq
);

    assign eq = &(~(a ^ b));

`ifdef AUTH_HAMMING_EN
    logic [WIDTH-1:0] diff;
    assign diff = a ^ b;

    always_comb begin
        dist = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            dist = dist + DIST_W'(diff[i]);
        end
    end
`endif

endmodule

// File: rtl/nbit_auth_lock.sv
// Sequential code-lock authenticator with failure counting and timed lockout.
// Optional feature: define AUTH_HAMMING_EN to report the Hamming distance of each accepted guess.
//   clk, rst_n          : clock, synchronous active-low reset
//   set_valid, set_code : program the secret code (ignored during lockout)
//   guess_valid, guess_code : submit an attempt (accepted only while armed)
//   armed               : code stored and not locked
//   matched, unmatched  : one-cycle result pulse for the previous accepted guess
//   locked              : lockout active
//   tries_left          : MAX_TRIES minus current consecutive failures
//   mismatch_bits       : Hamming distance of last accepted guess (0 when feature disabled)
module nbit_auth_lock
    import auth_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            set_valid,
    input  logic [WIDTH-1:0]                set_code,
    input  logic                            guess_valid,
    input  logic [WIDTH-1:0]                guess_code,
    output logic                            armed,
    output logic                            matched,
    output logic                            unmatched,
    output logic                            locked,
    output logic [cnt_width(MAX_TRIES)-1:0] tries_left,
    output logic [cnt_width(WIDTH)-1:0]     mismatch_bits
);

    localparam int unsigned TW = cnt_width(MAX_TRIES);
    localparam int unsigned LW = cnt_width(LOCK_CYCLES);
    localparam int unsigned DW = cnt_width(WIDTH);

    localparam logic [TW-1:0] MaxTriesW = TW'(MAX_TRIES);
    localparam logic [TW-1:0] LastTry   = TW'(MAX_TRIES - 1);
    localparam logic [LW-1:0] LockLoad  = LW'(LOCK_CYCLES);

    auth_state_e      state_q, state_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [TW-1:0]    fail_q, fail_d;
    logic [LW-1:0]    timer_q, timer_d;
    logic             matched_q, matched_d;
    logic             unmatched_q, unmatched_d;
    logic             cmp_eq;

`ifdef AUTH_HAMMING_EN
    logic [DW-1:0] cmp_dist;
    logic [DW-1:0] dist_q, dist_d;
`endif

    auth_compare #(
        .WIDTH  (WIDTH),
        .DIST_W (DW)
    ) u_compare (
        .a    (guess_code),
        .b    (code_q),
`ifdef AUTH_HAMMING_EN
        .dist (cmp_dist),
`endif
        .eq   (cmp_eq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StUnset;
            code_q      <= '0;
            fail_q      <= '0;
            timer_q     <= '0;
            matched_q   <= 1'b0;
            unmatched_q <= 1'b0;
`ifdef AUTH_HAMMING_EN
            dist_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            fail_q      <= fail_d;
            timer_q     <= timer_d;
            matched_q   <= matched_d;
            unmatched_q <= unmatched_d;
`ifdef AUTH_HAMMING_EN
            dist_q      <= dist_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        fail_d      = fail_q;
        timer_d     = timer_q;
        matched_d   = 1'b0;
        unmatched_d = 1'b0;
`ifdef AUTH_HAMMING_EN
        dist_d      = dist_q;
`endif
        case (state_q)
            StUnset: begin
                if (set_valid) begin
                    code_d  = set_code;
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // Rekey has priority; a simultaneous guess is dropped.
                if (set_valid) begin
                    code_d = set_code;
                    fail_d = '0;
                end else if (guess_valid) begin
`ifdef AUTH_HAMMING_EN
                    dist_d = cmp_dist;
`endif
                    if (cmp_eq) begin
                        matched_d = 1'b1;
                        fail_d    = '0;
                    end else begin
                        unmatched_d = 1'b1;
                        if (fail_q >= LastTry) begin
                            // Counter parks at MAX_TRIES so tries_left reads 0 while locked.
                            fail_d  = MaxTriesW;
                            timer_d = LockLoad;
                            state_d = StLockout;
                        end else begin
                            fail_d = fail_q + TW'(1);
                        end
                    end
                end
            end
            StLockout: begin
                // Timer holds the locked cycles remaining, including the current one.
                if (timer_q <= LW'(1)) begin
                    timer_d = '0;
                    fail_d  = '0;
                    state_d = StArmed;
                end else begin
                    timer_d = timer_q - LW'(1);
                end
            end
            default: begin
                state_d = StUnset;
            end
        endcase
    end

    assign armed      = (state_q == StArmed);
    assign locked     = (state_q == StLockout);
    assign matched    = matched_q;
    assign unmatched  = unmatched_q;
    assign tries_left = MaxTriesW - fail_q;

`ifdef AUTH_HAMMING_EN
    assign mismatch_bits = dist_q;
`else
    assign mismatch_bits = '0;
`endif

endmodule

// File: tb/tb_nbit_auth_lock.sv
// Self-checking bench for nbit_auth_lock: directed scenarios plus randomized traffic,
// compared every cycle against a cycle-count behavioural model.
module tb_nbit_auth_lock;

    localparam int WIDTH       = 8;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             set_valid;
    logic [WIDTH-1:0] set_code;
    logic             guess_valid;
    logic [WIDTH-1:0] guess_code;
    logic             armed;
    logic             matched;
    logic             unmatched;
    logic             locked;
    logic [1:0]       tries_left;
    logic [3:0]       mismatch_bits;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    bit         m_have;
    logic [7:0] m_code;
    int         m_fails;
    int         m_lock_rem;
    int         m_dist;
    bit         m_match;
    bit         m_unmatch;

    nbit_auth_lock #(
        .WIDTH       (WIDTH),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .set_valid     (set_valid),
        .set_code      (set_code),
        .guess_valid   (guess_valid),
        .guess_code    (guess_code),
        .armed         (armed),
        .matched       (matched),
        .unmatched     (unmatched),
        .locked        (locked),
        .tries_left    (tries_left),
        .mismatch_bits (mismatch_bits)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input logic [7:0] sc,
                              input bit g, input logic [7:0] gc);
        m_match   = 0;
        m_unmatch = 0;
        if (!r) begin
            m_have = 0; m_code = '0; m_fails = 0; m_lock_rem = 0; m_dist = 0;
        end else if (m_lock_rem > 0) begin
            m_lock_rem--;
            if (m_lock_rem == 0) m_fails = 0;
        end else if (s) begin
            m_have  = 1;
            m_code  = sc;
            m_fails = 0;
        end else if (g && m_have) begin
            m_dist = $countones(gc ^ m_code);
            if (gc == m_code) begin
                m_match = 1;
                m_fails = 0;
            end else begin
                m_unmatch = 1;
                m_fails++;
                if (m_fails == MAX_TRIES) m_lock_rem = LOCK_CYCLES;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("matched", 32'(matched), 32'(m_match));
        check_eq("unmatched", 32'(unmatched), 32'(m_unmatch));
        check_eq("armed", 32'(armed), 32'(m_have && m_lock_rem == 0));
        check_eq("locked", 32'(locked), 32'(m_lock_rem > 0));
        check_eq("tries_left", 32'(tries_left), 32'(MAX_TRIES - m_fails));
`ifdef AUTH_HAMMING_EN
        check_eq("mismatch_bits", 32'(mismatch_bits), 32'(m_dist));
`else
        check_eq("mismatch_bits", 32'(mismatch_bits), 32'd0);
`endif
        check_eq("pulse_excl", 32'(matched & unmatched), 32'd0);
    endtask

    // Drive one cycle of inputs, clock it, update the model, then sample #1 after the edge.
    task automatic step(input bit r, input bit s, input logic [7:0] sc,
                        input bit g, input logic [7:0] gc);
        rst_n       = r;
        set_valid   = s;
        set_code    = sc;
        guess_valid = g;
        guess_code  = gc;
        @(posedge clk);
        model_edge(r, s, sc, g, gc);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1, 0, 8'h00, 0, 8'h00);
    endtask

    int lock_len;

    initial begin
        // 1. reset, guess before any set
        step(0, 0, 8'h00, 0, 8'h00);
        check_eq("rst_tries", 32'(tries_left), 32'd3);
        step(1, 0, 8'h00, 1, 8'hA5);
        idle();
        check_eq("unset_armed", 32'(armed), 32'd0);

        // 2. set and matching guess
        step(1, 1, 8'hA5, 0, 8'h00);
        step(1, 0, 8'h00, 1, 8'hA5);
        check_eq("t2_matched", 32'(matched), 32'd1);
        idle();
        check_eq("t2_pulse_len", 32'(matched), 32'd0);

        // 3. single mismatch
        step(1, 0, 8'h00, 1, 8'h5A);
        check_eq("t3_tries", 32'(tries_left), 32'd2);

        // 4. lockout after three back-to-back mismatches (counter restarts after a match)
        step(1, 0, 8'h00, 1, 8'hA5);
        step(1, 0, 8'h00, 1, 8'h00);
        step(1, 0, 8'h00, 1, 8'h00);
        step(1, 0, 8'h00, 1, 8'h00);
        check_eq("t4_locked", 32'(locked), 32'd1);
        lock_len = 1;
        step(1, 0, 8'h00, 1, 8'hA5);
        if (locked) lock_len++;
        step(1, 1, 8'hFF, 0, 8'h00);
        if (locked) lock_len++;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (locked) lock_len++;
        end
        check_eq("t4_lock_len", 32'(lock_len), 32'(LOCK_CYCLES));
        step(1, 0, 8'h00, 1, 8'hA5);
        check_eq("t4_code_kept", 32'(matched), 32'd1);

        // 5. simultaneous set and guess
        step(1, 1, 8'h3C, 1, 8'h3C);
        check_eq("t5_no_pulse", 32'(matched | unmatched), 32'd0);
        step(1, 0, 8'h00, 1, 8'h3C);
        check_eq("t5_matched", 32'(matched), 32'd1);

        // 6. reset mid-lockout
        for (int i = 0; i < MAX_TRIES; i++) step(1, 0, 8'h00, 1, 8'h01);
        idle();
        idle();
        step(0, 0, 8'h00, 0, 8'h00);
        check_eq("t6_locked", 32'(locked), 32'd0);
        check_eq("t6_armed", 32'(armed), 32'd0);

        // Randomized traffic; guesses biased toward the stored code and its neighbours.
        for (int i = 0; i < 1500; i++) begin
            automatic bit         r  = ($urandom_range(0, 199) != 0);
            automatic bit         s  = ($urandom_range(0, 19) == 0);
            automatic bit         g  = ($urandom_range(0, 2) != 0);
            automatic logic [7:0] sc = 8'($urandom_range(0, 255));
            automatic logic [7:0] gc;
            case ($urandom_range(0, 3))
                0, 1:    gc = m_code;
                2:       gc = m_code ^ 8'(1 << $urandom_range(0, 7));
                default: gc = 8'($urandom_range(0, 255));
            endcase
            step(r, s, sc, g, gc);
        end

        $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
        $finish;
    end

endmodule
